request_queue_unit: RTL
=======================

# request_queue_unit

Parametrised successor to the single-entry request unit. It sits between the datapath and the I/D caches and queues up to DEPTH outstanding data requests (load or store) in program order. Instruction fetch keeps running while the queue has room, and a halt request drains the queue before the unit reports halted.

## Interface
Parameters:
- DEPTH, 2: queue entries; power of two, ≥2.
- WORD_W, 32: address/data width; equals width of word_t.

Ports:
- CLK  in  1  clock; all state on rising edge.
- RST  in  1  reset, synchronous, active-high.
- ihit_in  in  1  icache hit; current instruction completes.
- dhit_in  in  1  dcache completes the head request.
- iREN_in  in  1  datapath wants instruction fetch.
- dREN_in, dWEN_in  in  1 each  current instruction carries load / store; mutually exclusive.
- iaddr_in  in  WORD_W  fetch address.
- daddr_in, store_in  in  WORD_W  data address / store data of current instruction.
- halt_in  in  1  halt request; sampled, sticky.
- ihit_out  out  1  instruction accepted, datapath may advance.
- dhit_out  out  1  head request retired (1-cycle pulse).
- iREN_out  out  1  fetch enable to icache.
- iaddr_out  out  WORD_W  equals iaddr_in.
- dREN_out, dWEN_out  out  1  head entry request type; 0 when empty.
- daddr_out, store_out  out  WORD_W  head entry fields; 0 when empty.
- count_out  out  $clog2(DEPTH+1)  occupancy.
- halted_out  out  1  unit halted and queue empty.
- stall_cnt_out, dhit_cnt_out  out  32 each  statistics (see Configuration).

## Operation
- States: RUN, DRAIN, HALTED.
- RUN → DRAIN when halt_in=1. DRAIN → HALTED when count=0. HALTED holds until RST.
- need_d = dREN_in | dWEN_in.
- accept = ihit_in & (state==RUN) & ~(need_d & full).
- ihit_out = accept, combinational.
- Enqueue on accept & need_d: write {dREN_in, dWEN_in, daddr_in, store_in} at wr_ptr; wr_ptr+1 mod DEPTH.
- Pop on dhit_in & ~empty: rd_ptr+1 mod DEPTH; dhit_out=1 that cycle. A dhit_in while empty is ignored: dhit_out=0, no state change.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- full is evaluated on registered count only. A same-cycle pop does not free a slot for a push.
- iREN_out = iREN_in & (state==RUN) & ~full.
- Outputs d*_out present the head entry combinationally from storage; entries retire strictly in FIFO order.
- halted_out = (state==HALTED).
- Reset mid-operation: queue flushed (pointers and count = 0), state RUN; in-flight dcache transaction abandoned.
- Reset values: dREN_out=dWEN_out=0, daddr_out=store_out=0, count_out=0, dhit_out=0, halted_out=0, stats=0.
- After reset, ihit_out and iREN_out follow their inputs per the equations above.

## Timing
- Enqueue latency: an entry pushed at edge N is on d*_out from cycle N+1 if the queue was empty.
- Pop: the next entry appears the cycle after the dhit_in edge.
- Full stall: iREN_out drops in the cycle after count reaches DEPTH and rises in the cycle after the first pop.
- Halt: halt_in seen at edge N → iREN_out=0 from cycle N+1. halted_out=1 one cycle after the last pop.
- No combinational path from dhit_in to iREN_out or ihit_out.

## Configuration
- REQ_QUEUE_STATS_EN defined:
  - stall_cnt_out increments each cycle iREN_in=1 & iREN_out=0 & state==RUN.
  - dhit_cnt_out increments on each dhit_out.
  - Both are 32-bit, saturating at 0xFFFF_FFFF.
- Undefined: both outputs tied to 0; no counter flops.

## Structure
- cpu_types_pkg gains:
  - req_entry_t, a packed struct {ren, wen, addr:word_t, data:word_t}.
  - rq_state_t enum {RUN, DRAIN, HALTED}.
- Sub-module req_fifo (DEPTH, entry type):
  - ports push, pop, din, dout, count, full, empty.
  - pointer wrap and count logic live here.
- Top holds the FSM, gating and stats.

## Test plan
- Reset, then single load (dREN_in=1, daddr_in=0x100, ihit_in pulse):
  - next cycle dREN_out=1, daddr_out=0x100, count_out=1;
  - dhit_in pulse → dhit_out=1, count_out=0.
- DEPTH=2, two stores (0x200/0xAA, 0x204/0xBB) then a load attempt:
  - count_out=2, iREN_out=0, ihit_out=0 for the load;
  - one dhit_in → iREN_out=1 next cycle, head=0x204/0xBB.
- Queue holds 1 entry, push and pop in the same cycle: count_out stays 1; head becomes the new entry.
- Four push/pop cycles with DEPTH=2: pointers wrap; FIFO order 0x10, 0x14, 0x18, 0x1C observed on daddr_out.
- halt_in with 2 entries queued:
  - iREN_out=0 next cycle; new ihit_in gives ihit_out=0;
  - after two dhit_in, halted_out=1.
- RST asserted with 2 entries queued: next cycle count_out=0, dREN_out=0, halted_out=0.
- With REQ_QUEUE_STATS_EN: a 3-cycle full stall gives stall_cnt_out=3; 3 retirements give dhit_cnt_out=3.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU-side types for the request queue unit.
//   word_t       - address/data word
//   req_entry_t  - one queued data request {ren, wen, addr, data}
//   rq_state_t   - request queue control state {RUN, DRAIN, HALTED}
//   sat_inc32    - saturating 32-bit increment used by statistics counters
package cpu_types_pkg;

  localparam int WORD_BITS = 32;

  typedef logic [WORD_BITS-1:0] word_t;

  typedef struct packed {
    logic  ren;
    logic  wen;
    word_t addr;
    word_t data;
  } req_entry_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } rq_state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/req_fifo.sv
// req_fifo: DEPTH-entry in-order queue of request entries.
//   clk, rst   - clock, synchronous active-high reset (flushes pointers/count)
//   push, din  - write din at tail (ignored when full)
//   pop        - retire head (ignored when empty)
//   dout       - head entry, all zeros when empty
//   count      - occupancy, full / empty flags derived from it
// DEPTH must be a power of two so pointers wrap by natural overflow.
module req_fifo
  import cpu_types_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = req_entry_t,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  entry_t        din,
  output entry_t        dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // Both guards use the registered count: a pop in the same cycle does
  // not open a slot for a push into a full queue.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign dout = empty ? '0 : mem[rd_ptr];

  // Storage is not reset; dout is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/request_queue_unit.sv
// request_queue_unit: queues up to DEPTH outstanding data requests between
// the datapath and the I/D caches, in program order, while instruction
// fetch continues as long as the queue has room. A halt request stops
// fetch, drains the queue, then reports halted.
//   CLK, RST              - clock, synchronous active-high reset
//   ihit_in / ihit_out    - icache hit / instruction accepted
//   dhit_in / dhit_out    - dcache completed head / head retired pulse
//   iREN_in/out, iaddr_*  - fetch request passthrough with gating
//   dREN_in, dWEN_in, daddr_in, store_in - data request of current instr
//   dREN_out, dWEN_out, daddr_out, store_out - head entry (0 when empty)
//   count_out             - occupancy
//   halt_in / halted_out  - sticky halt request / halted and drained
//   stall_cnt_out, dhit_cnt_out - statistics
// Optional feature macro: REQ_QUEUE_STATS_EN enables the saturating
// statistics counters; without it both outputs are tied to zero.
module request_queue_unit
  import cpu_types_pkg::*;
#(
  parameter int  DEPTH  = 2,
  parameter int  WORD_W = 32,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit_in,
  input  logic              dhit_in,
  input  logic              iREN_in,
  input  logic              dREN_in,
  input  logic              dWEN_in,
  input  logic [WORD_W-1:0] iaddr_in,
  input  logic [WORD_W-1:0] daddr_in,
  input  logic [WORD_W-1:0] store_in,
  input  logic              halt_in,
  output logic              ihit_out,
  output logic              dhit_out,
  output logic              iREN_out,
  output logic [WORD_W-1:0] iaddr_out,
  output logic              dREN_out,
  output logic              dWEN_out,
  output logic [WORD_W-1:0] daddr_out,
  output logic [WORD_W-1:0] store_out,
  output logic [CW-1:0]     count_out,
  output logic              halted_out,
  output logic [31:0]       stall_cnt_out,
  output logic [31:0]       dhit_cnt_out
);

  if (WORD_W != $bits(word_t)) begin : g_width_check
    $error("WORD_W must equal the width of word_t");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("DEPTH must be a power of two and at least 2");
  end

  rq_state_t   state;
  req_entry_t  din, head;
  logic        full, empty, need_d, accept, push, pop;
  logic [CW-1:0] count;

  assign need_d = dREN_in | dWEN_in;
  // full is registered, so neither accept nor iREN_out depends on dhit_in.
  assign accept = ihit_in & (state == RUN) & ~(need_d & full);
  assign push   = accept & need_d;
  assign pop    = dhit_in & ~empty;

  assign din.ren  = dREN_in;
  assign din.wen  = dWEN_in;
  assign din.addr = daddr_in;
  assign din.data = store_in;

  req_fifo #(.DEPTH(DEPTH), .entry_t(req_entry_t)) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (halt_in) state <= DRAIN;
        DRAIN:   if (count == '0) state <= HALTED;
        HALTED:  state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

  assign ihit_out   = accept;
  assign dhit_out   = pop;
  assign iREN_out   = iREN_in & (state == RUN) & ~full;
  assign iaddr_out  = iaddr_in;
  assign dREN_out   = head.ren;
  assign dWEN_out   = head.wen;
  assign daddr_out  = head.addr;
  assign store_out  = head.data;
  assign count_out  = count;
  assign halted_out = (state == HALTED);

`ifdef REQ_QUEUE_STATS_EN
  logic [31:0] stall_cnt, dhit_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
      dhit_cnt  <= '0;
    end else begin
      if (iREN_in & ~iREN_out & (state == RUN)) stall_cnt <= sat_inc32(stall_cnt);
      if (dhit_out) dhit_cnt <= sat_inc32(dhit_cnt);
    end
  end

  assign stall_cnt_out = stall_cnt;
  assign dhit_cnt_out  = dhit_cnt;
`else
  assign stall_cnt_out = '0;
  assign dhit_cnt_out  = '0;
`endif

endmodule
